// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the 640x480@60 raster.
// Also holds the sync polarity and the coordinate width.
package vga_timing_pkg;

  // Coordinate width and the largest raster total it can address
  localparam int COORD_W     = 10;
  localparam int COORD_LIMIT = 1 << COORD_W;

  // Horizontal timing (pixels)
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  // Vertical timing (lines)
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Both sync signals are active low
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: div_cnt counts 0..CLK_DIV-1 and wraps.
// pix_tick is high in the last system clock of each pixel period.
// With CLK_DIV=1, pix_tick is permanently high.
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_tick
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Divider counter, restarting at zero after the last clock of a pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign pix_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel divider, horizontal/vertical counters,
// and registered hsync/vsync/blank that line up with pos_h/pos_v.
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN adds an 8-bit frame counter port.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_tick,
  output logic [COORD_W-1:0] pos_h,
  output logic [COORD_W-1:0] pos_v,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               frame_end
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Raster totals must fit the coordinate width; the divider is 1..16
  if (H_TOTAL > COORD_LIMIT) begin : g_h_total_check
    $error("vga_sync_gen: H_TOTAL exceeds coordinate range");
  end
  if (V_TOTAL > COORD_LIMIT) begin : g_v_total_check
    $error("vga_sync_gen: V_TOTAL exceeds coordinate range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_clk_div_check
    $error("vga_sync_gen: CLK_DIV out of range 1..16");
  end

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  // Decode thresholds carry one extra bit so a sync region ending exactly
  // at the coordinate limit still compares correctly.
  localparam logic [COORD_W:0] H_VIS_END    = (COORD_W+1)'(H_VISIBLE);
  localparam logic [COORD_W:0] H_SYNC_START = (COORD_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W:0] H_SYNC_END   = (COORD_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W:0] V_VIS_END    = (COORD_W+1)'(V_VISIBLE);
  localparam logic [COORD_W:0] V_SYNC_START = (COORD_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W:0] V_SYNC_END   = (COORD_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] h_next;
  logic [COORD_W-1:0] v_next;
  logic               hsync_next;
  logic               vsync_next;
  logic               blank_next;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick)
  );

  // Next raster position: advance one pixel per tick, wrapping line and frame
  always_comb begin
    h_next = pos_h;
    v_next = pos_v;
    if (pix_tick) begin
      if (pos_h == H_LAST) begin
        h_next = '0;
        if (pos_v == V_LAST) begin
          v_next = '0;
        end else begin
          v_next = pos_v + {{(COORD_W-1){1'b0}}, 1'b1};
        end
      end else begin
        h_next = pos_h + {{(COORD_W-1){1'b0}}, 1'b1};
      end
    end else begin
      h_next = pos_h;
      v_next = pos_v;
    end
  end

  // Sync/blank decode from the next position so the registered outputs match the counters
  always_comb begin
    hsync_next = SYNC_IDLE;
    vsync_next = SYNC_IDLE;
    blank_next = 1'b0;
    if (({1'b0, h_next} >= H_SYNC_START) && ({1'b0, h_next} < H_SYNC_END)) begin
      hsync_next = SYNC_ACTIVE;
    end else begin
      hsync_next = SYNC_IDLE;
    end
    if (({1'b0, v_next} >= V_SYNC_START) && ({1'b0, v_next} < V_SYNC_END)) begin
      vsync_next = SYNC_ACTIVE;
    end else begin
      vsync_next = SYNC_IDLE;
    end
    if (({1'b0, h_next} >= H_VIS_END) || ({1'b0, v_next} >= V_VIS_END)) begin
      blank_next = 1'b1;
    end else begin
      blank_next = 1'b0;
    end
  end

  // Raster counters and registered sync/blank outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_h <= '0;
      pos_v <= '0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
      blank <= 1'b0;
    end else begin
      pos_h <= h_next;
      pos_v <= v_next;
      hsync <= hsync_next;
      vsync <= vsync_next;
      blank <= blank_next;
    end
  end

  assign frame_end = pix_tick && (pos_h == H_LAST) && (pos_v == V_LAST);

`ifdef VGA_SYNC_FRAME_CNT_EN
  // Frame counter, advancing once per completed frame and wrapping at 255
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 8'd0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 8'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen.
// dut_a: default 640x480 timing, CLK_DIV=4 (reset, divider, horizontal line).
// dut_b: small raster 15x12, CLK_DIV=1 (full frame, frame_end, mid-frame reset,
//        frame counter when VGA_SYNC_FRAME_CNT_EN is defined).
module tb_vga_sync_gen;

  logic clk;
  logic rst_a;
  logic rst_b;

  logic       a_tick, a_hs, a_vs, a_blank, a_fe;
  logic [9:0] a_h, a_v;
  logic       b_tick, b_hs, b_vs, b_blank, b_fe;
  logic [9:0] b_h, b_v;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] a_fcnt;
  logic [7:0] b_fcnt;
`endif

  int checks = 0;
  int errors = 0;

  vga_sync_gen #(.CLK_DIV(4)) dut_a (
    .clk       (clk),
    .reset     (rst_a),
    .pix_tick  (a_tick),
    .pos_h     (a_h),
    .pos_v     (a_v),
    .hsync     (a_hs),
    .vsync     (a_vs),
    .blank     (a_blank),
    .frame_end (a_fe)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt (a_fcnt)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .clk       (clk),
    .reset     (rst_b),
    .pix_tick  (b_tick),
    .pos_h     (b_h),
    .pos_v     (b_v),
    .hsync     (b_hs),
    .vsync     (b_vs),
    .blank     (b_blank),
    .frame_end (b_fe)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt (b_fcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;

    // ---------------- dut_a: reset for 3 cycles, then release
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    // cycle 1 after release: reset values
    chk("a_rst_pos_h", 32'(a_h), 32'd0);
    chk("a_rst_pos_v", 32'(a_v), 32'd0);
    chk("a_rst_hsync", 32'(a_hs), 32'd1);
    chk("a_rst_vsync", 32'(a_vs), 32'd1);
    chk("a_rst_blank", 32'(a_blank), 32'd0);
    chk("a_rst_tick", 32'(a_tick), 32'd0);
    chk("a_rst_frame_end", 32'(a_fe), 32'd0);
    // cycles 2..4: first tick in cycle 4
    @(negedge clk); chk("a_tick_c2", 32'(a_tick), 32'd0);
    @(negedge clk); chk("a_tick_c3", 32'(a_tick), 32'd0);
    @(negedge clk); chk("a_tick_c4", 32'(a_tick), 32'd1);
    chk("a_pos_h_c4", 32'(a_h), 32'd0);
    @(negedge clk);
    chk("a_pos_h_c5", 32'(a_h), 32'd1);

    // ---------------- dut_a: one full line, every cycle of each pixel
    for (int h = 1; h < 800; h++) begin
      for (int k = 0; k < 4; k++) begin
        chk("a_line_pos_h", 32'(a_h), 32'(h));
        chk("a_line_pos_v", 32'(a_v), 32'd0);
        chk("a_line_tick", 32'(a_tick), (k == 3) ? 32'd1 : 32'd0);
        chk("a_line_blank", 32'(a_blank), (h >= 640) ? 32'd1 : 32'd0);
        chk("a_line_hsync", 32'(a_hs), (h >= 656 && h < 752) ? 32'd0 : 32'd1);
        chk("a_line_vsync", 32'(a_vs), 32'd1);
        chk("a_line_frame_end", 32'(a_fe), 32'd0);
        @(negedge clk);
      end
    end
    // 799 -> 0 and pos_v 0 -> 1 on the same edge
    chk("a_wrap_pos_h", 32'(a_h), 32'd0);
    chk("a_wrap_pos_v", 32'(a_v), 32'd1);
    chk("a_wrap_blank", 32'(a_blank), 32'd0);
    chk("a_wrap_hsync", 32'(a_hs), 32'd1);
    rst_a = 1'b1;

    // ---------------- dut_b: CLK_DIV=1, walk one complete 15x12 frame
    @(negedge clk);
    rst_b = 1'b0;
    for (int v = 0; v < 12; v++) begin
      for (int h = 0; h < 15; h++) begin
        chk("b_frame_pos_h", 32'(b_h), 32'(h));
        chk("b_frame_pos_v", 32'(b_v), 32'(v));
        chk("b_frame_tick", 32'(b_tick), 32'd1);
        chk("b_frame_blank", 32'(b_blank), (h >= 8 || v >= 6) ? 32'd1 : 32'd0);
        chk("b_frame_hsync", 32'(b_hs), (h >= 10 && h < 13) ? 32'd0 : 32'd1);
        chk("b_frame_vsync", 32'(b_vs), (v >= 7 && v < 9) ? 32'd0 : 32'd1);
        chk("b_frame_end", 32'(b_fe), (h == 14 && v == 11) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
    end
    // frame length 180 cycles: back at (0,0)
    chk("b_wrap_pos_h", 32'(b_h), 32'd0);
    chk("b_wrap_pos_v", 32'(b_v), 32'd0);
    chk("b_wrap_frame_end", 32'(b_fe), 32'd0);

    // ---------------- dut_b: reset in the middle of both sync pulses
    repeat (8 * 15 + 12) @(negedge clk);
    chk("b_mid_pos_h", 32'(b_h), 32'd12);
    chk("b_mid_pos_v", 32'(b_v), 32'd8);
    chk("b_mid_hsync", 32'(b_hs), 32'd0);
    chk("b_mid_vsync", 32'(b_vs), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_mrst_pos_h", 32'(b_h), 32'd0);
    chk("b_mrst_pos_v", 32'(b_v), 32'd0);
    chk("b_mrst_hsync", 32'(b_hs), 32'd1);
    chk("b_mrst_vsync", 32'(b_vs), 32'd1);
    chk("b_mrst_blank", 32'(b_blank), 32'd0);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_restart_pos_h", 32'(b_h), 32'd1);
    chk("b_restart_pos_v", 32'(b_v), 32'd0);
    chk("b_restart_hsync", 32'(b_hs), 32'd1);

`ifdef VGA_SYNC_FRAME_CNT_EN
    // ---------------- dut_b: frame counter over 257 frames
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_fcnt_rst", 32'(b_fcnt), 32'd0);
    rst_b = 1'b0;
    repeat (180) @(negedge clk);
    chk("b_fcnt_1", 32'(b_fcnt), 32'd1);
    repeat (255 * 180) @(negedge clk);
    chk("b_fcnt_wrap0", 32'(b_fcnt), 32'd0);
    repeat (180) @(negedge clk);
    chk("b_fcnt_257", 32'(b_fcnt), 32'd1);
    chk("b_fcnt_pos_h", 32'(b_h), 32'd0);
    chk("b_fcnt_pos_v", 32'(b_v), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Display timing generator that drives the VGA pixel-generation blocks. It divides the system clock down to a pixel rate and runs horizontal and vertical raster counters. From those counters it produces `hsync`, `vsync`, `blank` and the `pos_h`/`pos_v` coordinates that rectangle and sprite renderers consume. It sits between the board clock/reset and every pixel-colour block, one instance per display.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (1..16).
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BACK`, 48: horizontal back porch.
- `V_VISIBLE`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BACK`, 33: vertical back porch.

Ports:
- `clk`  in  1  system clock. Single clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `pix_tick`  out  1  one-`clk` pulse per pixel period.
- `pos_h`  out  10  horizontal counter, 0..H_TOTAL-1.
- `pos_v`  out  10  vertical counter, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `blank`  out  1  high outside the visible area.
- `frame_end`  out  1  one-`clk` pulse on the last pixel of a frame.
- `frame_cnt`  out  8  frame counter. Present only with `VGA_SYNC_FRAME_CNT_EN`.

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL is defined the same way (525). Both totals must be ≤1024; an elaboration-time check enforces this.
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps.
- `pix_tick` = (`div_cnt` == CLK_DIV-1). With CLK_DIV=1, `pix_tick` is constant 1 out of reset.
- On a `clk` edge with `pix_tick`=1:
  - `pos_h` increments.
  - At H_TOTAL-1, `pos_h` wraps to 0 and `pos_v` increments.
  - At V_TOTAL-1 (with `pos_h` also at H_TOTAL-1), `pos_v` wraps to 0.
- Without `pix_tick`, all counters hold.
- `blank` = (`pos_h` ≥ H_VISIBLE) or (`pos_v` ≥ V_VISIBLE).
- `hsync` = 0 iff H_VISIBLE+H_FRONT ≤ `pos_h` < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- `vsync` = 0 iff V_VISIBLE+V_FRONT ≤ `pos_v` < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
- `hsync`, `vsync` and `blank` are registered. They are computed from next-state counter values, so they always describe the `pos_h`/`pos_v` presented in the same cycle.
- `frame_end` = `pix_tick` & (`pos_h` == H_TOTAL-1) & (`pos_v` == V_TOTAL-1).

## Timing
- Reset values: `div_cnt`=0, `pos_h`=0, `pos_v`=0, `hsync`=1, `vsync`=1, `blank`=0, `pix_tick`=0 (CLK_DIV>1), `frame_end`=0, `frame_cnt`=0.
- First `pix_tick` occurs in the CLK_DIV-th cycle after `reset` deasserts. `pos_h` reads 1 on the following cycle.
- Each pixel value is held for exactly CLK_DIV `clk` cycles. A line lasts H_TOTAL·CLK_DIV cycles; a frame lasts H_TOTAL·V_TOTAL·CLK_DIV cycles.
- Zero latency between the counters and the sync/blank outputs: they change on the same edge.
- Reset asserted mid-frame takes effect at the next edge. All state returns to reset values with no partial sync pulse; `hsync` and `vsync` go high immediately.
- `frame_end` and the `pos_v` wrap coincide: `frame_end` is high in the cycle before `pos_h`/`pos_v` read 0,0.

## Configuration
- Macro `VGA_SYNC_FRAME_CNT_EN`.
- Defined: the `frame_cnt` port and register exist. `frame_cnt` increments on each `frame_end` and wraps 255→0; reset clears it to 0.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Structure
- Package `vga_timing_pkg` holds:
  - 640x480@60 default timing constants (visible, porches, sync widths, totals).
  - Sync polarity constants.
  - Coordinate width constant (10).
- Sub-module `vga_pix_tick` holds the divider counter and the `pix_tick` pulse, parameterised by CLK_DIV.
- Raster counters and sync decode stay in `vga_sync_gen`.

## Test plan
- **Reset:** hold `reset` for 3 cycles, release → all outputs at reset values. First `pix_tick` arrives in cycle 4 (CLK_DIV=4) and repeats every 4 cycles.
- **Horizontal boundaries:** run one line → `blank` 0 for `pos_h` 0..639 and 1 at 640. `hsync` low exactly for `pos_h` 656..751. `pos_h` goes 799→0 and `pos_v` goes 0→1 on the same edge.
- **Vertical boundaries:** run one frame → `blank` 1 for `pos_v` 480..524. `vsync` low only on lines 490..491. `frame_end` pulses once, at (799,524), and is followed by (0,0).
- **Reset mid-frame:** assert `reset` at `pos_h`=700, `pos_v`=491 → next cycle `hsync`=1, `vsync`=1, `pos_h`=0, `pos_v`=0; timing restarts cleanly.
- **CLK_DIV=1:** `pix_tick` constant 1 after reset; frame length is 420000 cycles.
- **With `VGA_SYNC_FRAME_CNT_EN`:** run 257 frames → `frame_cnt` reads 1 after wrapping through 255→0.
